// File: rtl/icache_refill.sv
// Instruction-cache refill engine: fetches one 128-bit line as four 32-bit memory beats
// and hands it back to the cache with a one-cycle ready pulse.
module icache_refill #(
    parameter int unsigned LINE_WIDTH      = 128,
    parameter int unsigned BEAT_WIDTH      = 32,
    parameter int unsigned LINE_ADDR_WIDTH = 28,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_i,
    input  logic [LINE_ADDR_WIDTH-1:0] req_addr_i,
    output logic [LINE_WIDTH-1:0]      fill_data_o,
    output logic [LINE_ADDR_WIDTH-1:0] fill_addr_o,
    output logic                       fill_rdy_o,
    output logic                       busy_o,
    output logic                       mem_req_o,
    output logic [31:0]                mem_addr_o,
    input  logic                       mem_gnt_i,
    input  logic                       mem_rvalid_i,
    input  logic [BEAT_WIDTH-1:0]      mem_rdata_i,
    output logic [CNT_WIDTH-1:0]       refill_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StBeat,
        StResp,
        StDrain
    } state_e;

    state_e                     state_q, state_d;
    logic [LINE_WIDTH-1:0]      line_q, line_d;
    logic [LINE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic [1:0]                 beat_q, beat_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            line_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    addr_d  = req_addr_i;
                    beat_d  = '0;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_gnt_i) begin
                    state_d = StBeat;
                end
            end
            StBeat: begin
                if (mem_rvalid_i) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (beat_q == 2'(k)) begin
                            line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata_i;
                        end
                    end
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StDrain;
            end
            StDrain: begin
                // Hold off until the cache drops its request so it cannot re-trigger a refill.
                if (!req_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign fill_data_o  = line_q;
    assign fill_addr_o  = addr_q;
    assign fill_rdy_o   = (state_q == StResp);
    assign busy_o       = (state_q != StIdle);
    assign mem_req_o    = (state_q == StReq);
    assign mem_addr_o   = 32'({addr_q, 4'b0000});
    assign refill_cnt_o = cnt_q;

endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill, checked against a transaction-level model of the refill
// protocol; a second instance with a 3-bit counter exercises counter saturation.
module tb_icache_refill;

    localparam int SAT_W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_i;
    logic [27:0]  req_addr_i;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [31:0]  mem_rdata_i;

    logic [127:0] fill_data_o;
    logic [27:0]  fill_addr_o;
    logic         fill_rdy_o;
    logic         busy_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic [15:0]  refill_cnt_o;

    logic [127:0]     s_fill_data;
    logic [27:0]      s_fill_addr;
    logic             s_fill_rdy;
    logic             s_busy;
    logic             s_mem_req;
    logic [31:0]      s_mem_addr;
    logic [SAT_W-1:0] s_cnt;

    always #5 clk = ~clk;

    icache_refill dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req_i),
        .req_addr_i   (req_addr_i),
        .fill_data_o  (fill_data_o),
        .fill_addr_o  (fill_addr_o),
        .fill_rdy_o   (fill_rdy_o),
        .busy_o       (busy_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .refill_cnt_o (refill_cnt_o)
    );

    icache_refill #(
        .CNT_WIDTH (SAT_W)
    ) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req_i),
        .req_addr_i   (req_addr_i),
        .fill_data_o  (s_fill_data),
        .fill_addr_o  (s_fill_addr),
        .fill_rdy_o   (s_fill_rdy),
        .busy_o       (s_busy),
        .mem_req_o    (s_mem_req),
        .mem_addr_o   (s_mem_addr),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .refill_cnt_o (s_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: number of accepted refills, expected line and latched address.
    longint       n_acc;
    logic [127:0] m_line;
    logic [27:0]  m_addr;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] exp_cnt(input int w);
        longint top;
        top = (longint'(1) << w) - 1;
        return 128'((n_acc > top) ? top : n_acc);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_cnt"}, 128'(refill_cnt_o), exp_cnt(16));
        check_eq({tag, "_cnt_sat"}, 128'(s_cnt), exp_cnt(SAT_W));
    endtask

    task automatic model_reset();
        n_acc  = 0;
        m_line = '0;
        m_addr = '0;
    endtask

    task automatic do_refill(input logic [27:0] addr, input int gnt_delay,
                             input int g0, input int g1, input int g2, input int g3,
                             input int sticky, input bit spurious, input bit pattern);
        int          gaps[4];
        logic [31:0] w;
        gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;

        req_i      = 1'b1;
        req_addr_i = addr;
        tick();
        n_acc++;
        m_addr = addr;
        check_eq("acc_busy", 128'(busy_o), 128'(1));
        check_eq("acc_mem_req", 128'(mem_req_o), 128'(1));
        check_eq("acc_mem_addr", 128'(mem_addr_o), 128'({addr, 4'h0}));
        check_eq("acc_fill_addr", 128'(fill_addr_o), 128'(addr));
        check_eq("acc_data_hold", fill_data_o, m_line);
        check_counts("acc");

        // Request phase; memory may stall the grant.
        for (int d = 0; d < gnt_delay; d++) begin
            mem_rvalid_i = spurious;
            mem_rdata_i  = $urandom;
            req_addr_i   = spurious ? 28'($urandom) : addr;
            tick();
            check_eq("req_held", 128'(mem_req_o), 128'(1));
            check_eq("req_addr_stable", 128'(mem_addr_o), 128'({addr, 4'h0}));
            check_eq("req_no_rdy", 128'(fill_rdy_o), 128'(0));
            check_eq("req_data_hold", fill_data_o, m_line);
        end

        // A beat presented on the grant edge itself must not be captured.
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = $urandom;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        check_eq("gnt_req_low", 128'(mem_req_o), 128'(0));
        check_eq("gnt_busy", 128'(busy_o), 128'(1));
        check_eq("gnt_no_capture", fill_data_o, m_line);

        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                mem_rvalid_i = 1'b0;
                mem_gnt_i    = spurious;
                req_addr_i   = spurious ? 28'($urandom) : addr;
                tick();
                check_eq("gap_no_rdy", 128'(fill_rdy_o), 128'(0));
                check_eq("gap_mem_req", 128'(mem_req_o), 128'(0));
                check_eq("gap_data", fill_data_o, m_line);
            end
            w            = pattern ? (32'hDDDDDDDD - 32'(b) * 32'h11111111) : $urandom;
            mem_gnt_i    = spurious;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = w;
            tick();
            mem_rvalid_i = 1'b0;
            mem_gnt_i    = 1'b0;
            m_line[32*b +: 32] = w;
            check_eq("beat_data", fill_data_o, m_line);
            check_eq("beat_rdy", 128'(fill_rdy_o), 128'(b == 3));
        end
        check_eq("resp_fill_addr", 128'(fill_addr_o), 128'(m_addr));
        check_counts("resp");

        // Request stays high after the response: no second refill may start.
        for (int s = 0; s < sticky; s++) begin
            req_i = 1'b1;
            tick();
            check_eq("sticky_no_rdy", 128'(fill_rdy_o), 128'(0));
            check_eq("sticky_no_mem_req", 128'(mem_req_o), 128'(0));
            check_eq("sticky_busy", 128'(busy_o), 128'(1));
            check_counts("sticky");
        end
        req_i      = 1'b0;
        req_addr_i = 28'($urandom);
        tick();
        if (sticky == 0) begin
            check_eq("drain_busy", 128'(busy_o), 128'(1));
            tick();
        end
        check_eq("idle_busy", 128'(busy_o), 128'(0));
        check_eq("idle_no_rdy", 128'(fill_rdy_o), 128'(0));
        check_eq("idle_data_hold", fill_data_o, m_line);
        check_eq("idle_addr_hold", 128'(fill_addr_o), 128'(m_addr));

        if (spurious) begin
            mem_rvalid_i = 1'b1;
            mem_gnt_i    = 1'b1;
            mem_rdata_i  = $urandom;
            tick();
            mem_rvalid_i = 1'b0;
            mem_gnt_i    = 1'b0;
            check_eq("spur_idle_busy", 128'(busy_o), 128'(0));
            check_eq("spur_idle_data", fill_data_o, m_line);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_busy"}, 128'(busy_o), 128'(0));
        check_eq({tag, "_mem_req"}, 128'(mem_req_o), 128'(0));
        check_eq({tag, "_rdy"}, 128'(fill_rdy_o), 128'(0));
        check_eq({tag, "_mem_addr"}, 128'(mem_addr_o), 128'(0));
        check_eq({tag, "_fill_addr"}, 128'(fill_addr_o), 128'(0));
        check_eq({tag, "_data"}, fill_data_o, 128'(0));
        check_counts(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        req_i        = 1'b0;
        req_addr_i   = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        model_reset();
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        // Basic minimum-latency refill, then a sticky request followed by a fresh one.
        do_refill(28'h0000001, 0, 0, 0, 0, 0, 4, 1'b0, 1'b1);
        check_eq("basic_line", fill_data_o, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        do_refill(28'h0000002, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        check_eq("second_cnt", 128'(refill_cnt_o), 128'(2));
        check_eq("second_addr", 128'(mem_addr_o), 128'h20);

        // Stalled grant and gapped beats.
        do_refill(28'($urandom), 7, 0, 0, 3, 1, 0, 1'b0, 1'b0);

        // Reset after two beats of a refill.
        req_i      = 1'b1;
        req_addr_i = 28'h0ABCDEF;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
            tick();
        end
        mem_rvalid_i = 1'b0;
        reset        = 1'b1;
        req_i        = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        check_reset_state("midrst");
        for (int b = 0; b < 2; b++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
            tick();
            check_eq("midrst_no_rdy", 128'(fill_rdy_o), 128'(0));
            check_eq("midrst_idle", 128'(busy_o), 128'(0));
            check_eq("midrst_data", fill_data_o, 128'(0));
        end
        mem_rvalid_i = 1'b0;

        // Randomized refills with spurious inputs; drives the small counter into saturation.
        for (int i = 0; i < 12; i++) begin
            do_refill(28'($urandom), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end
        check_eq("sat_final", 128'(s_cnt), 128'(7));
        check_eq("cnt_final", 128'(refill_cnt_o), 128'(12));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
# icache_refill

Instruction-side refill engine sitting directly downstream of the instruction cache's miss port and upstream of the backing memory bus. It accepts a single-line refill request (line address), fetches the line from memory as four 32-bit beats, assembles it into a 128-bit line, and returns it to the cache with a one-cycle ready pulse. One refill is outstanding at a time. A saturating refill counter is exposed for performance monitoring.

## Interface

Parameters:

- `LINE_WIDTH`, default 128: refill line width in bits. Fixed at 4 × `BEAT_WIDTH`.
- `BEAT_WIDTH`, default 32: memory data bus width in bits.
- `LINE_ADDR_WIDTH`, default 28: width of the line address (byte address [31:4]).
- `CNT_WIDTH`, default 16: width of the refill counter.

Ports:

- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `req_i`: input, 1 bit. Refill request from the cache; level, held until `fill_rdy_o` is seen.
- `req_addr_i`: input, `LINE_ADDR_WIDTH` bits. Line address of the request.
- `fill_data_o`: output, `LINE_WIDTH` bits. Assembled line. Word k sits at [32k+31:32k].
- `fill_addr_o`: output, `LINE_ADDR_WIDTH` bits. Latched line address of the current or last refill.
- `fill_rdy_o`: output, 1 bit. One-cycle pulse when `fill_data_o` is valid.
- `busy_o`: output, 1 bit. High in every state except IDLE.
- `mem_req_o`: output, 1 bit. Memory read request.
- `mem_addr_o`: output, 32 bits. Byte address `{fill_addr_o, 4'b0000}`.
- `mem_gnt_i`: input, 1 bit. Memory accepts the request in this cycle.
- `mem_rvalid_i`: input, 1 bit. Read beat valid.
- `mem_rdata_i`: input, `BEAT_WIDTH` bits. Read beat data, delivered in ascending word order.
- `refill_cnt_o`: output, `CNT_WIDTH` bits. Number of accepted refills, saturating.

## Operation

States: IDLE, REQ, BEAT, RESP, DRAIN.

- **IDLE**
  - If `req_i`=1: latch `req_addr_i` into `fill_addr_o`, clear the beat counter, increment `refill_cnt_o` (hold at all-ones), and go to REQ.
  - Otherwise, stay in IDLE.
- **REQ**
  - `mem_req_o`=1 and `mem_addr_o` are held stable.
  - On `mem_gnt_i`=1, go to BEAT.
  - There is no timeout; REQ is held indefinitely.
- **BEAT**
  - On each edge with `mem_rvalid_i`=1, write `mem_rdata_i` into word[beat_cnt] and increment the 2-bit `beat_cnt`.
  - When the 4th beat is captured (beat_cnt 3→0 wrap), go to RESP.
  - Gaps (`mem_rvalid_i`=0) are allowed and simply hold the state.
- **RESP**
  - `fill_rdy_o`=1 for exactly this cycle; `fill_data_o` holds the full line.
  - Unconditionally go to DRAIN.
- **DRAIN**
  - Wait for `req_i`=0, then go to IDLE. This prevents a stale, still-high request from triggering a duplicate refill.
- **Ignored inputs:**
  - `mem_rvalid_i` outside BEAT.
  - `mem_gnt_i` outside REQ.
  - `req_addr_i` changes outside IDLE.
- **Data hold:** `fill_data_o` and `fill_addr_o` keep their values until the next accepted request.
  - `fill_addr_o` updates on acceptance.
  - Line words overwrite beat by beat.

## Timing

- Reset values:
  - State: IDLE.
  - `fill_rdy_o`=0, `busy_o`=0, `mem_req_o`=0.
  - `mem_addr_o`=0, `fill_addr_o`=0, `fill_data_o`=0.
  - `refill_cnt_o`=0, beat_cnt=0.
- Reset mid-operation, in any state: return to IDLE on that edge and discard partial line words.
  - A request already granted by memory is abandoned; its later beats arrive in IDLE and are ignored.
- All outputs are registered, decoded from state or regs.
  - `mem_req_o` is high the cycle after the edge that accepts `req_i`.
- Minimum latency, with `req_i` sampled at edge 0, grant at edge 1, and beats at edges 2–5:
  - `fill_rdy_o` is high between edges 5 and 6, i.e. 5 cycles from request to ready.
- An `mem_rvalid_i` at the grant edge is not captured. The earliest capturable beat is the edge after the grant.
- `req_i` high continuously through RESP: the block stays in DRAIN, and `refill_cnt_o` does not increment again until `req_i` drops and rises.
- Counter at all-ones plus a new accepted request: it stays at all-ones.

## Test plan

- **Basic refill.** `reset` for 2 cycles; `req_i`=1 with `req_addr_i`=28'h0000001; `mem_gnt_i` 1 cycle later; beats DDDDDDDD, CCCCCCCC, BBBBBBBB, AAAAAAAA back-to-back.
  - Expect `mem_addr_o`=32'h00000010.
  - Expect `fill_rdy_o` for exactly 1 cycle, 5 cycles after acceptance.
  - Expect `fill_data_o`=128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD and `refill_cnt_o`=1.
- **Stalls.** Grant delayed 7 cycles; beats separated by 0, 3 and 1 idle cycles.
  - Expect `mem_req_o` held high for 8 cycles with a stable address.
  - Expect the correct line assembled and `fill_rdy_o` on the cycle after the 4th beat.
- **Sticky request.** Hold `req_i`=1 for 4 cycles after `fill_rdy_o`, then drop it, then raise it with addr 28'h0000002.
  - Expect no second `mem_req_o` until after the drop.
  - Expect `refill_cnt_o` to go 1→2 only on the new request, with `mem_addr_o`=32'h00000020.
- **Reset mid-refill.** Assert `reset` after 2 beats.
  - Expect IDLE, `busy_o`=0 and `fill_data_o`=0 next cycle.
  - Drive 2 more `mem_rvalid_i` beats: expect no `fill_rdy_o`.
- **Spurious inputs.** `mem_rvalid_i` pulsed in IDLE and in REQ, `mem_gnt_i` pulsed in BEAT, and `req_addr_i` changed during BEAT.
  - Expect no state or data effect, and `fill_addr_o` unchanged.
- **Saturation.** Run 65,537 refills with `CNT_WIDTH`=16.
  - Expect `refill_cnt_o`=16'hFFFF held.
